// File: rtl/interval_timer_pkg.sv
// Shared types and constants for the interval timer and its counter.
package interval_timer_pkg;

  // FSM states; the encoding is held in a register.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int DEFAULT_WORD_WIDTH = 8;

  // All-zeros count word, cast to the instance width where it is used.
  localparam logic [DEFAULT_WORD_WIDTH-1:0] WORD_ZERO = '0;

endpackage

// File: rtl/interval_timer_if.sv
// Handshake and status bundle between the timer and its user.
interface interval_timer_if #(
  parameter int WORD_WIDTH = 8
);
  logic                  interval_valid;
  logic                  interval_ready;
  logic [WORD_WIDTH-1:0] interval;
  logic                  tick;
  logic                  abort;
  logic                  running;
  logic [WORD_WIDTH-1:0] remaining;
  logic                  expired_valid;
  logic                  expired_ready;

  // User side: offers intervals and ticks, consumes expiry.
  modport master (
    output interval_valid, interval, tick, abort, expired_ready,
    input  interval_ready, running, remaining, expired_valid
  );

  // Timer side.
  modport slave (
    input  interval_valid, interval, tick, abort, expired_ready,
    output interval_ready, running, remaining, expired_valid
  );
endinterface

// File: rtl/interval_timer_counter_binary.sv
// Binary up/down counter with synchronous clear, parallel load and run enable.
// up_down=1 counts down by INCREMENT+carry_in, up_down=0 counts up.
module Counter_Binary #(
  parameter int WORD_WIDTH    = 8,
  parameter int INCREMENT     = 1,
  parameter int INITIAL_COUNT = 0
) (
  input  logic                  clock,
  input  logic                  clear,
  input  logic                  up_down,
  input  logic                  run,
  input  logic                  load,
  input  logic [WORD_WIDTH-1:0] load_count,
  input  logic                  carry_in,
  output logic [WORD_WIDTH-1:0] count
);
  localparam logic [WORD_WIDTH-1:0] INC_W  = WORD_WIDTH'(INCREMENT);
  localparam logic [WORD_WIDTH-1:0] INIT_W = WORD_WIDTH'(INITIAL_COUNT);

  logic [WORD_WIDTH-1:0] count_q;
  logic [WORD_WIDTH-1:0] count_d;
  logic [WORD_WIDTH-1:0] carry_w;

  assign carry_w = {{(WORD_WIDTH-1){1'b0}}, carry_in};

  // Next count: load wins over run; otherwise hold.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_count;
    end else if (run) begin
      if (up_down) count_d = count_q - INC_W - carry_w;
      else         count_d = count_q + INC_W + carry_w;
    end
  end

  // Count register.
  always_ff @(posedge clock) begin
    if (clear) count_q <= INIT_W;
    else       count_q <= count_d;
  end

  assign count = count_q;
endmodule

// File: rtl/interval_timer.sv
// Handshaked down-counting interval timer.
//
//  state   | meaning
//  --------+-----------------------------------------------
//  IDLE    | waiting for an interval word, interval_ready=1
//  RUN     | counting down by DECREMENT on each tick
//  DONE    | expiry offered, held until expired_ready
module interval_timer
  import interval_timer_pkg::*;
#(
  parameter int WORD_WIDTH = 8,
  parameter int DECREMENT  = 1
) (
  input  logic              clock,
  input  logic              clear,
  interval_timer_if.slave   bus
);
  localparam logic [WORD_WIDTH-1:0] DEC_W  = WORD_WIDTH'(DECREMENT);
  localparam logic [WORD_WIDTH-1:0] ZERO_W = WORD_WIDTH'(WORD_ZERO);

  state_e                state_q;
  state_e                state_d;
  logic                  cnt_load;
  logic                  cnt_run;
  logic [WORD_WIDTH-1:0] cnt_load_count;
  logic [WORD_WIDTH-1:0] remaining_w;
  logic                  accept_w;
  logic                  last_tick_w;

  // Counter saturates via a load of zero on the final tick, so it never wraps
  // and its carry path is not needed.
  Counter_Binary #(
    .WORD_WIDTH   (WORD_WIDTH),
    .INCREMENT    (DECREMENT),
    .INITIAL_COUNT(0)
  ) u_counter (
    .clock     (clock),
    .clear     (clear),
    .up_down   (1'b1),
    .run       (cnt_run),
    .load      (cnt_load),
    .load_count(cnt_load_count),
    .carry_in  (1'b0),
    .count     (remaining_w)
  );

  assign bus.interval_ready = (state_q == ST_IDLE) && !clear;
  assign bus.running        = (state_q == ST_RUN);
  assign bus.expired_valid  = (state_q == ST_DONE);
  assign bus.remaining      = remaining_w;

  assign accept_w    = bus.interval_valid && bus.interval_ready;
  assign last_tick_w = (remaining_w <= DEC_W);

  // Next state and counter control; abort outranks tick in RUN.
  always_comb begin
    state_d        = state_q;
    cnt_load       = 1'b0;
    cnt_run        = 1'b0;
    cnt_load_count = ZERO_W;
    case (state_q)
      ST_IDLE: begin
        if (accept_w) begin
          cnt_load       = 1'b1;
          cnt_load_count = bus.interval;
          state_d        = (bus.interval != ZERO_W) ? ST_RUN : ST_DONE;
        end
      end
      ST_RUN: begin
        if (bus.abort) begin
          cnt_load = 1'b1;
          state_d  = ST_IDLE;
        end else if (bus.tick) begin
          if (last_tick_w) begin
            cnt_load = 1'b1;
            state_d  = ST_DONE;
          end else begin
            cnt_run = 1'b1;
          end
        end
      end
      ST_DONE: begin
        if (bus.expired_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clock) begin
    if (clear) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end
endmodule
